// File: rtl/jpeg_cone_pkg.sv
// Shared types and the per-lane cone function for the JPEG cone lane array.
// The evaluator works on a fixed maximum width; callers zero-extend and truncate.
package jpeg_cone_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;
    localparam int LANES_MAX  = 64;

    typedef enum logic [1:0] {
        CONE  = 2'd0,
        XCONE = 2'd1,
        GATE  = 2'd2,
        INV   = 2'd3
    } cone_mode_e;

    function automatic logic [LANES_MAX-1:0] cone_eval(
        input logic [LANES_MAX-1:0] a,
        input logic [LANES_MAX-1:0] b,
        input logic [LANES_MAX-1:0] c,
        input cone_mode_e           mode
    );
        logic [LANES_MAX-1:0] en;
        en = b & ~c;
        case (mode)
            CONE:    return ~(a ^ en);
            XCONE:   return a ^ en;
            GATE:    return en;
            default: return ~a;
        endcase
    endfunction

endpackage

// File: rtl/jpeg_cone_slice.sv
// One elastic register slice: loads when empty or when its beat leaves downstream.
module jpeg_cone_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid;
    logic [W-1:0] data;

    // Ready ripples combinationally back from the downstream consumer.
    assign in_ready  = ~valid | out_ready;
    assign out_valid = valid;
    assign out_data  = data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (in_ready) begin
            valid <= in_valid;
            if (in_valid)
                data <= in_data;
        end
    end

endmodule

// File: rtl/jpeg_cone_lane_array.sv
// Multi-lane cone evaluator feeding an elastic slice chain, plus a saturating
// counter of delivered all-ones beats.
module jpeg_cone_lane_array
    import jpeg_cone_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_a,
    input  logic [LANES-1:0] in_b,
    input  logic [LANES-1:0] in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_y,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("jpeg_cone_lane_array: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    end
    if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
        $error("jpeg_cone_lane_array: LANES=%0d outside 1..%0d", LANES, LANES_MAX);
    end

    logic [LANES_MAX-1:0] a_w, b_w, c_w;

    always_comb begin
        a_w = '0;
        b_w = '0;
        c_w = '0;
        a_w[LANES-1:0] = in_a;
        b_w[LANES-1:0] = in_b;
        c_w[LANES-1:0] = in_c;
    end

    // Index 0 is the evaluator output; index i+1 is the output of slice i.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            rdy_pipe;
    logic [STAGES:0][LANES-1:0] dat_pipe;

    assign vld_pipe[0]      = in_valid;
    assign dat_pipe[0]      = LANES'(cone_eval(a_w, b_w, c_w, cone_mode_e'(in_mode)));
    assign rdy_pipe[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        jpeg_cone_slice #(.W(LANES)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld_pipe[i]),
            .in_ready  (rdy_pipe[i]),
            .in_data   (dat_pipe[i]),
            .out_valid (vld_pipe[i+1]),
            .out_ready (rdy_pipe[i+1]),
            .out_data  (dat_pipe[i+1])
        );
    end

    assign in_ready  = rdy_pipe[0];
    assign out_valid = vld_pipe[STAGES];
    assign out_y     = dat_pipe[STAGES];

    // Clear wins over a coincident qualifying transfer.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            match_cnt <= '0;
        else if (out_valid && out_ready && (&out_y) && (match_cnt != {CNT_W{1'b1}}))
            match_cnt <= match_cnt + 1'b1;
    end

endmodule
